ut_control_unit: RTL

Sequencer for the UT accumulator processor: fetches 8-bit instructions from the unified 64×8 memory and drives the program counter's clear/load/enable controls, the memory strobes, the instruction register and the accumulator/carry load strobes. It sits between the memory and the datapath, and is the controlling end of the program-counter interface. It supplies `ADR_IN` through `ir_adr` and consumes `ADR_OUT` as `pc_adr`.

---
 rtl/ut_control_unit_if.sv | 32 +++
 rtl/ut_control_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ut_control_unit_if.sv
// Bus between the UT control unit and its memory/datapath/PC neighbours.
// The master modport belongs to the control unit; the slave modport belongs to its environment.
interface ut_control_unit_if;
    logic       ce;
    logic [7:0] data_in;
    logic       carry;
    logic [5:0] pc_adr;
    logic [5:0] ir_adr;
    logic       clear_PC;
    logic       load_PC;
    logic       enable_PC;
    logic       sel_adr;
    logic       mem_ce;
    logic       mem_we;
    logic       load_ACC;
    logic       alu_op;
    logic       load_carry;
    logic       clear_carry;
    logic       halted;

    modport master (
        input  ce, data_in, carry, pc_adr,
        output ir_adr, clear_PC, load_PC, enable_PC, sel_adr, mem_ce, mem_we,
               load_ACC, alu_op, load_carry, clear_carry, halted
    );

    modport slave (
        output ce, data_in, carry, pc_adr,
        input  ir_adr, clear_PC, load_PC, enable_PC, sel_adr, mem_ce, mem_we,
               load_ACC, alu_op, load_carry, clear_carry, halted
    );
endinterface

// File: rtl/ut_control_unit.sv
// Fetch/decode/execute sequencer for the UT accumulator processor.
// Optional macro UT_HALT_EN adds a HALT state entered by a taken self-loop JCC.
module ut_control_unit (
    input  logic                  clk,
    input  logic                  rst,
    ut_control_unit_if.master     bus
);

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StDecode,
        StExec,
        StAlu
`ifdef UT_HALT_EN
        , StHalt
`endif
    } state_t;

    localparam logic [1:0] OpNor = 2'b00;
    localparam logic [1:0] OpAdd = 2'b01;
    localparam logic [1:0] OpSta = 2'b10;
    localparam logic [1:0] OpJcc = 2'b11;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_ir;
    logic [7:0] w_ir_next;

    logic w_active;
    logic w_clear_pc;
    logic w_load_pc;
    logic w_enable_pc;
    logic w_sel_adr;
    logic w_mem_ce;
    logic w_mem_we;
    logic w_load_acc;
    logic w_load_carry;
    logic w_clear_carry;

`ifdef UT_HALT_EN
    logic w_self_loop;
    // PC has already post-incremented past the JCC by the time it executes.
    assign w_self_loop = (r_ir[5:0] == (bus.pc_adr - 6'd1));
`else
    logic w_unused_pc;
    assign w_unused_pc = ^bus.pc_adr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StInit;
            r_ir    <= 8'h00;
        end else if (bus.ce) begin
            r_state <= w_state_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ir_next     = r_ir;
        w_clear_pc    = 1'b0;
        w_load_pc     = 1'b0;
        w_enable_pc   = 1'b0;
        w_sel_adr     = 1'b0;
        w_mem_ce      = 1'b0;
        w_mem_we      = 1'b0;
        w_load_acc    = 1'b0;
        w_load_carry  = 1'b0;
        w_clear_carry = 1'b0;

        unique case (r_state)
            StInit: begin
                w_clear_pc   = 1'b1;
                w_enable_pc  = 1'b1;
                w_state_next = StFetch;
            end
            StFetch: begin
                w_mem_ce     = 1'b1;
                w_enable_pc  = 1'b1;
                w_state_next = StDecode;
            end
            StDecode: begin
                w_ir_next    = bus.data_in;
                w_state_next = StExec;
            end
            StExec: begin
                unique case (r_ir[7:6])
                    OpNor, OpAdd: begin
                        w_sel_adr    = 1'b1;
                        w_mem_ce     = 1'b1;
                        w_state_next = StAlu;
                    end
                    OpSta: begin
                        w_sel_adr    = 1'b1;
                        w_mem_ce     = 1'b1;
                        w_mem_we     = 1'b1;
                        w_state_next = StFetch;
                    end
                    OpJcc: begin
                        w_state_next = StFetch;
                        if (bus.carry) begin
                            w_clear_carry = 1'b1;
`ifdef UT_HALT_EN
                        end else if (w_self_loop) begin
                            w_state_next = StHalt;
`endif
                        end else begin
                            w_load_pc = 1'b1;
                        end
                    end
                    default: w_state_next = StFetch;
                endcase
            end
            StAlu: begin
                w_load_acc   = 1'b1;
                w_load_carry = r_ir[6];
                w_state_next = StFetch;
            end
`ifdef UT_HALT_EN
            StHalt: w_state_next = StHalt;
`endif
            default: w_state_next = StInit;
        endcase
    end

    // Strobes are forced low while frozen and while reset is held, even in INIT.
    assign w_active = bus.ce & rst;

    assign bus.clear_PC    = w_active & w_clear_pc;
    assign bus.load_PC     = w_active & w_load_pc;
    assign bus.enable_PC   = w_active & w_enable_pc;
    assign bus.sel_adr     = w_active & w_sel_adr;
    assign bus.mem_ce      = w_active & w_mem_ce;
    assign bus.mem_we      = w_active & w_mem_we;
    assign bus.load_ACC    = w_active & w_load_acc;
    assign bus.load_carry  = w_active & w_load_carry;
    assign bus.clear_carry = w_active & w_clear_carry;

    assign bus.ir_adr = r_ir[5:0];
    assign bus.alu_op = r_ir[6];

`ifdef UT_HALT_EN
    assign bus.halted = (r_state == StHalt);
`else
    assign bus.halted = 1'b0;
`endif

endmodule
